serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder, DIGIT bits per clock, valid/ready on both sides
// Optional signed-overflow output Ovf is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT:0]   w_slice;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    assign w_slice    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
    // Slice sum enters at the MSB end; widened concat keeps DIGIT == WIDTH legal.
    assign w_acc_next = WIDTH'({w_slice[DIGIT-1:0], r_acc} >> DIGIT);
    assign w_last     = (r_state == RUN) && (r_cnt == CW'(N - 1));

`ifdef SERIAL_ADDER_OVF_EN
    logic w_carry_into_msb;
    // Recover the carry into the top bit from that bit's sum and operand bits.
    assign w_carry_into_msb = w_slice[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
`endif

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            S       <= '0;
            Cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            Ovf     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= Cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_acc   <= w_acc_next;
                    r_carry <= w_slice[DIGIT];
                    r_cnt   <= r_cnt + CW'(1);
                    // S/Cout only change when a result completes.
                    if (w_last) begin
                        S    <= w_acc_next;
                        Cout <= w_slice[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                        Ovf  <= w_carry_into_msb ^ w_slice[DIGIT];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] A, B, S;
    logic         Cin, Cout;
    logic         in_valid1, in_ready1, out_valid1, out_ready1;
    logic [W-1:0] A1, B1, S1;
    logic         Cin1, Cout1;
`ifdef SERIAL_ADDER_OVF_EN
    logic         Ovf, Ovf1;
`endif

    serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .Ovf(Ovf)
`endif
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .A(A1), .B(B1), .Cin(Cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .S(S1), .Cout(Cout1)
`ifdef SERIAL_ADDER_OVF_EN
        , .Ovf(Ovf1)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[10];
    int   n_checks;
    int   n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after consumption.
    task automatic run_op(input vec_t v);
        int n;
        check("ready_before", {31'd0, in_ready}, 32'd1);
        A = v.a; B = v.b; Cin = v.cin; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A = ~v.a; B = ~v.b; Cin = ~v.cin;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, N);
        check("sum", {24'd0, S}, {24'd0, v.s});
        check("cout", {31'd0, Cout}, {31'd0, v.cout});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", {31'd0, Ovf}, {31'd0, v.ovf});
`endif
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("ready_after", {31'd0, in_ready}, 32'd1);
        check("valid_after", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int   n;
        vec_t v;
        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[9] = '{8'h01, 8'h7F, 1'b1, 8'h81, 1'b0, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; A1 = '0; B1 = '0; Cin1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {24'd0, S}, 32'd0);
        check("rst_cout", {31'd0, Cout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i]);
        end

        // Backpressure: new operands held on in_valid while DONE stalls.
        A = 8'h12; B = 8'h34; Cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        A = 8'h01; B = 8'h01;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", n, N);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_sum", {24'd0, S}, 32'h46);
            check("bp_cout", {31'd0, Cout}, 32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accepted", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp2_latency", n, N);
        check("bp2_sum", {24'd0, S}, 32'h02);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset two cycles into RUN discards the operation and clears S.
        A = 8'hC3; B = 8'h11; Cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_sum", {24'd0, S}, 32'd0);
        check("mid_rst_cout", {31'd0, Cout}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        v = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        run_op(v);

        // Single-slice instance: result one cycle after accept.
        A1 = 8'h80; B1 = 8'h80; Cin1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        check("d8_run_valid", {31'd0, out_valid1}, 32'd0);
        @(negedge clk);
        check("d8_valid", {31'd0, out_valid1}, 32'd1);
        check("d8_sum", {24'd0, S1}, 32'd0);
        check("d8_cout", {31'd0, Cout1}, 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
        check("d8_ovf", {31'd0, Ovf1}, 32'd1);
`endif
        @(negedge clk);
        check("d8_ready", {31'd0, in_ready1}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
